// File: rtl/store_aux.sv
// store_aux: store-merge helper for the MIPS multicycle datapath.
//
// This block builds the 32-bit word that is written back to memory for sw, sh
// and sb. It takes the low word, halfword or byte of the store-data register
// and merges it into the current memory word. The result is registered, so it
// appears one cycle after the inputs are sampled.
//
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous, active-high; clears data_out and byte_en at once
//   selector  store type: 00=sw, 01=sh, 10=sb, 11=no-store
//   data_0    store data (rt / B register value)
//   data_1    current memory word (MDR) at the target address
//   data_out  registered merged word for the memory write-data port
//   byte_en   registered with data_out; bit i set means byte i of data_out
//             came from data_0
//
// DATA_W must stay 32. The byte and halfword lanes are hard-wired to [7:0]
// and [15:0].

module store_aux #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        selector,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        byte_en
);

  localparam logic [1:0] SEL_SW = 2'b00;
  localparam logic [1:0] SEL_SH = 2'b01;
  localparam logic [1:0] SEL_SB = 2'b10;

  logic [DATA_W-1:0] merge_data;
  logic [3:0]        merge_en;

  // The default arm doubles as the no-store pass-through. An undefined
  // selector therefore rewrites the existing memory word rather than
  // injecting store data.
  always_comb begin
    merge_data = data_1;
    merge_en   = 4'b0000;
    case (selector)
      SEL_SW: begin
        merge_data = data_0;
        merge_en   = 4'b1111;
      end
      SEL_SH: begin
        merge_data = {data_1[DATA_W-1:16], data_0[15:0]};
        merge_en   = 4'b0011;
      end
      SEL_SB: begin
        merge_data = {data_1[DATA_W-1:8], data_0[7:0]};
        merge_en   = 4'b0001;
      end
      default: begin
        merge_data = data_1;
        merge_en   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      byte_en  <= 4'b0000;
    end else begin
      data_out <= merge_data;
      byte_en  <= merge_en;
    end
  end

endmodule

// File: tb/tb_store_aux.sv
// Self-checking bench for store_aux.
// The driver applies inputs on the falling edge and pushes the expected result
// into a queue. The monitor pops one entry after each rising edge and compares
// it with the outputs. Asynchronous reset behaviour and holding between edges
// are checked directly.

module tb_store_aux;

  logic        clk;
  logic        reset;
  logic [1:0]  selector;
  logic [31:0] data_0;
  logic [31:0] data_1;
  logic [31:0] data_out;
  logic [3:0]  byte_en;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  en;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  store_aux #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .selector (selector),
    .data_0   (data_0),
    .data_1   (data_1),
    .data_out (data_out),
    .byte_en  (byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: selector picks how many low bytes come from data_0;
  // every other byte keeps its value from data_1.
  function automatic exp_t model(input logic [1:0] sel, input logic [31:0] d0,
                                 input logic [31:0] d1, input string nm);
    exp_t e;
    int nbytes;
    nbytes = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : (sel == 2'd2) ? 1 : 0;
    e.data = d1;
    e.en   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i < nbytes) begin
        e.data[i*8 +: 8] = d0[i*8 +: 8];
        e.en[i] = 1'b1;
      end
    end
    e.name = nm;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] got_d, input logic [3:0] got_e,
                       input logic [31:0] want_d, input logic [3:0] want_e);
    n_tests++;
    if (got_d !== want_d || got_e !== want_e) begin
      n_fail++;
      $display("FAIL %s: data_out=%h byte_en=%b, expected data_out=%h byte_en=%b",
               nm, got_d, got_e, want_d, want_e);
    end
  endtask

  // Drive one transaction for the next rising edge.
  task automatic step(input logic [1:0] sel, input logic [31:0] d0,
                      input logic [31:0] d1, input string nm);
    @(negedge clk);
    selector = sel;
    data_0   = d0;
    data_1   = d1;
    exp_q.push_back(model(sel, d0, d1, nm));
  endtask

  // Monitor: each rising edge out of reset presents a fresh output.
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, data_out, byte_en, e.data, e.en);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    selector = 2'b00;
    data_0   = 32'hFFFF_FFFF;
    data_1   = 32'h0000_0000;

    // Assert reset between edges; the outputs must clear without an edge.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("reset_async", data_out, byte_en, 32'h0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", data_out, byte_en, 32'h0, 4'b0000);

    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(model(2'b00, 32'hFFFF_FFFF, 32'h0, "post_reset_sw"));
    step(2'b01, 32'hFFFF_FFFF, 32'h0, "sh_ones");
    step(2'b10, 32'hFFFF_FFFF, 32'h0, "sb_ones");
    step(2'b11, 32'h1234_5678, 32'hAABB_CCDD, "nostore");
    step(2'b01, 32'h1234_5678, 32'hAABB_CCDD, "sh_merge");
    step(2'b10, 32'h1234_5678, 32'hAABB_CCDD, "sb_merge");
    step(2'b00, 32'h1234_5678, 32'hAABB_CCDD, "sw_merge");
    @(posedge clk);
    #2;

    // Latency: change the selector between edges; the output must not move.
    selector = 2'b10;
    #1 check("latency_hold", data_out, byte_en, 32'h1234_5678, 4'b1111);
    @(posedge clk);
    #2 check("latency_update", data_out, byte_en, 32'hAABB_CC78, 4'b0001);

    // Mid-stream reset pulse between edges.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("midreset_async", data_out, byte_en, 32'h0, 4'b0000);
    #1 reset = 1'b0;
    #1 check("midreset_no_edge", data_out, byte_en, 32'h0, 4'b0000);
    exp_q.push_back(model(2'b10, 32'h1234_5678, 32'hAABB_CCDD, "midreset_resume"));
    @(posedge clk);
    #2;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), $urandom, $urandom, "random");
    end
    @(posedge clk);
    #3;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
